// File: rtl/vga_sync_gen.sv
// Purpose: VGA 640x480@60 sync/timing generator: hsync, vsync, video_on, pixel coordinates, line/frame pulses.
// Latency: all outputs are registered and lag the internal h/v counters by exactly one enabled (pix_en) edge.
// Backpressure: none; pix_en stalls counters and holds outputs, while line/frame pulses drop to 0 on stalled edges.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode bounds are 11 bits wide so a 1024-long line still compares correctly.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        hs_act;
  logic        vs_act;

  assign h_ext  = {1'b0, h_cnt_q};
  assign v_ext  = {1'b0, v_cnt_q};
  assign hs_act = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_act = (v_ext >= VS_START) && (v_ext < VS_END);

  // Next state: decode current counters into the output registers and advance raster position when enabled.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      pixel_x_d     = h_cnt_q;
      pixel_y_d     = v_cnt_q;
      video_on_d    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
      hsync_d       = hs_act ? SYNC_POL : ~SYNC_POL;
      vsync_d       = vs_act ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (h_cnt_q == 10'd0);
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // State registers; reset wins over pix_en and restarts the frame at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Pixel-timing stage directly downstream of the 25 MHz clock generator: consumes the pixel clock and produces VGA 640x480@60 Hz horizontal/vertical sync, an active-video qualifier and the current pixel coordinates. Feeds the pixel/colour generation stages and the VGA connector pins. All outputs are registered and mutually aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)

Ports:
clk  in  1  pixel clock from clock_gen (25 MHz nominal)
rst  in  1  synchronous reset, active-high
pix_en  in  1  pixel clock-enable; counters and outputs advance only when 1
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
video_on  out  1  1 while (pixel_x, pixel_y) is inside the visible area
pixel_x  out  10  horizontal position of current output pixel, 0..799
pixel_y  out  10  vertical position of current output pixel, 0..524
line_start  out  1  one-cycle pulse when pixel_x = 0
frame_start  out  1  one-cycle pulse when pixel_x = 0 and pixel_y = 0

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); all state updates on rising edge of clk.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Counters are 10 bits; parameters must give totals <= 1024.
- Internal counters h_cnt, v_cnt. On an edge with rst=1: h_cnt=0, v_cnt=0; hsync=vsync=inactive (!SYNC_POL); video_on=0; pixel_x=0; pixel_y=0; line_start=0; frame_start=0. rst has priority over pix_en.
- On an edge with rst=0, pix_en=1:
  - Output registers load the decode of the current (h_cnt, v_cnt): pixel_x<=h_cnt, pixel_y<=v_cnt; video_on<=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE); hsync active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); vsync active iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491); line_start<=(h_cnt==0); frame_start<=(h_cnt==0 && v_cnt==0).
  - Counters advance: h_cnt==H_TOTAL-1 -> h_cnt=0 and v_cnt increments (v_cnt==V_TOTAL-1 -> v_cnt=0); otherwise h_cnt+1, v_cnt holds.
- On an edge with rst=0, pix_en=0: counters and hsync/vsync/video_on/pixel_x/pixel_y hold; line_start and frame_start forced to 0 (pulses never stretch).
- Latency: outputs lag internal counters by exactly one enabled edge; hsync, vsync, video_on, pixel_x/y, pulses always describe the same pixel.
- First enabled edge after reset release: pixel_x=0, pixel_y=0, video_on=1, line_start=1, frame_start=1, syncs inactive.
- Wrap: after pixel (799,524) the next output pixel is (0,0) with frame_start=1; after (799,y) next is (0,y+1).
- Reset mid-frame: at the reset edge all outputs return to reset values; the frame restarts at (0,0) on the first enabled edge after release — no partial-line continuation.
- Frame period with pix_en tied high: 420000 clk cycles; line period 800.

Test Plan:
- Reset/startup: hold rst 3 cycles with pix_en=1, release -> during reset hsync=vsync=1, video_on=0, pixel_x=pixel_y=0; first edge after release pixel=(0,0), video_on=1, frame_start=1.
- Horizontal timing: pix_en=1, one line -> video_on high for pixel_x 0..639, low 640..799; hsync low exactly pixel_x 656..751 (96 cycles); line_start every 800 cycles.
- Vertical timing/wrap: run 2 full frames -> vsync low exactly for lines 490..491 (1600 cycles); video_on never high for pixel_y>=480; frame_start pulses 420000 cycles apart; pixel (799,524) followed by (0,0).
- Clock enable: pix_en toggled 1/0 each cycle -> line_start spacing 1600 cycles; outputs hold on pix_en=0 cycles; line_start/frame_start never high two consecutive cycles.
- Reset mid-operation: assert rst at pixel (300,200) for 1 cycle -> outputs at reset values next cycle; sequence resumes at (0,0) with frame_start=1.
- Polarity: SYNC_POL=1 -> hsync/vsync idle 0, high during 656..751 / lines 490..491; reset value 0.
